// File: rtl/pulse_meter_pkg.sv
// Shared definitions for the pulse period meter: FSM state encoding and
// the default values of the meter parameters.
package pulse_meter_pkg;

    // Measurement FSM states; the encoding is also visible on the debug port.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2,
        ST_STALL   = 2'd3
    } meter_state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_CNT_WIDTH     = 32;
    localparam int DEF_TIMEOUT_COUNT = 100_000_000;

endpackage

// File: rtl/signal_sync_edge.sv
// Brings an asynchronous level into the i_clk domain through a flop chain
// and flags the cycle in which the synchronized level first goes high.
// SYNC_STAGES is meant to be 2..4.
module signal_sync_edge
    import pulse_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    // Shift the async input through the synchronizer, then keep one cycle of history.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // A rise is the synchronized level high while the previous cycle was low.
    // Because history resets to 0, a signal already high at reset release
    // yields exactly one rise.
    assign o_level = sync_q[SYNC_STAGES-1];
    assign o_rise  = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the period and high time of an asynchronous square wave in i_clk
// cycles and flags a stall when rising edges stop arriving.
//
// Output protocol: o_valid is a one-cycle strobe with no back-pressure.
// In the cycle o_valid is high, o_period and o_high_time hold a fresh
// measurement; they keep that value until the next strobe, a stall
// (both forced to 0) or reset. o_dbg_state mirrors the FSM state register.
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int TIMEOUT_COUNT = DEF_TIMEOUT_COUNT
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic                 i_sig,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic [CNT_WIDTH-1:0] o_high_time,
    output logic                 o_valid,
    output logic                 o_stalled,
    output logic [1:0]           o_dbg_state
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_COUNT - 1);

    meter_state_t         state_q, state_d;
    logic [CNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_WIDTH-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0] period_out_d, high_out_d;
    logic                 valid_d, stalled_d;
    logic                 sig_level, sig_rise, timeout_hit;

    signal_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_sig),
        .o_level (sig_level),
        .o_rise  (sig_rise)
    );

    // The period counter is the only thing that can run away; it stops at
    // TIMEOUT_COUNT-1, so neither counter can wrap.
    assign timeout_hit = (period_cnt_q == TIMEOUT_LAST);

    // Next-state, counter and output-register logic; a rise takes priority
    // over a timeout in the same cycle, and a low enable overrides everything.
    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        period_out_d = o_period;
        high_out_d   = o_high_time;
        valid_d      = 1'b0;
        stalled_d    = o_stalled;

        if (!i_enable) begin
            state_d      = ST_IDLE;
            period_cnt_d = '0;
            high_cnt_d   = '0;
            stalled_d    = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    period_cnt_d = '0;
                    high_cnt_d   = '0;
                    state_d      = ST_ARM;
                end
                ST_ARM: begin
                    if (sig_rise) begin
                        period_cnt_d = '0;
                        high_cnt_d   = CNT_ONE;
                        state_d      = ST_MEASURE;
                    end else if (timeout_hit) begin
                        state_d      = ST_STALL;
                        stalled_d    = 1'b1;
                        period_out_d = '0;
                        high_out_d   = '0;
                    end else begin
                        period_cnt_d = period_cnt_q + CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    if (sig_rise) begin
                        period_out_d = period_cnt_q + CNT_ONE;
                        high_out_d   = high_cnt_q;
                        valid_d      = 1'b1;
                        stalled_d    = 1'b0;
                        period_cnt_d = '0;
                        high_cnt_d   = CNT_ONE;
                    end else if (timeout_hit) begin
                        state_d      = ST_STALL;
                        stalled_d    = 1'b1;
                        period_out_d = '0;
                        high_out_d   = '0;
                    end else begin
                        period_cnt_d = period_cnt_q + CNT_ONE;
                        if (sig_level) begin
                            high_cnt_d = high_cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_STALL: begin
                    // Restart timing like ARM; o_stalled stays set until a
                    // full period has been measured.
                    if (sig_rise) begin
                        period_cnt_d = '0;
                        high_cnt_d   = CNT_ONE;
                        state_d      = ST_MEASURE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            o_period     <= '0;
            o_high_time  <= '0;
            o_valid      <= 1'b0;
            o_stalled    <= 1'b0;
        end else begin
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            o_period     <= period_out_d;
            o_high_time  <= high_out_d;
            o_valid      <= valid_d;
            o_stalled    <= stalled_d;
        end
    end

    assign o_dbg_state = state_q;

endmodule
